// File: rtl/voice_mixer_if.sv
// Handshake bundle between dynamics_calc, voice_mixer and the codec path.
// The mixer takes the slave view; the upstream/codec side (or a bench) takes the master view.
interface voice_mixer_if;
  logic               samples_in_ready;
  logic signed [15:0] sample_in1;
  logic signed [15:0] sample_in2;
  logic signed [15:0] sample_in3;
  logic signed [15:0] sample_in4;
  logic signed [15:0] sample_in5;
  logic signed [15:0] sample_in6;
  logic signed [15:0] sample_in7;
  logic signed [15:0] sample_in8;
  logic [7:0]         mute_mask;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic               sample_out_ack;
  logic               busy;
  logic               clip;
  logic               dropped;

  modport master (
    output samples_in_ready,
    output sample_in1, sample_in2, sample_in3, sample_in4,
    output sample_in5, sample_in6, sample_in7, sample_in8,
    output mute_mask,
    output sample_out_ack,
    input  sample_out, sample_out_valid, busy, clip, dropped
  );

  modport slave (
    input  samples_in_ready,
    input  sample_in1, sample_in2, sample_in3, sample_in4,
    input  sample_in5, sample_in6, sample_in7, sample_in8,
    input  mute_mask,
    input  sample_out_ack,
    output sample_out, sample_out_valid, busy, clip, dropped
  );
endinterface

// File: rtl/voice_mixer.sv
// Serial eight-voice mixer: accumulates one voice per cycle, then shifts,
// saturates and holds a signed 16-bit result behind a valid/ack handshake.
module voice_mixer #(
  parameter int OUT_SHIFT = 1
) (
  input logic          clk,
  input logic          reset,
  voice_mixer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;

  localparam logic signed [18:0] SAT_MAX = 19'sd32767;
  localparam logic signed [18:0] SAT_MIN = -19'sd32768;

  state_t state, state_next;

  logic signed [15:0] voice [8];
  logic [7:0]         mask_q;
  logic [2:0]         idx;
  logic signed [18:0] acc;
  logic signed [18:0] addend;
  logic signed [18:0] scaled;
  logic signed [15:0] clamped;
  logic               clipped;
  logic signed [15:0] out_q;
  logic               clip_q;
  logic               dropped_q;
  logic               accept;
  logic               reject;

  // A new set is only taken when idle or when the held result is consumed on the same edge.
  always_comb begin
    accept = bus.samples_in_ready &&
             ((state == IDLE) || ((state == HOLD) && bus.sample_out_ack));
    reject = bus.samples_in_ready && !accept;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment up front keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = ACCUM;
      ACCUM: if (idx == 3'd7) state_next = SCALE;
      SCALE: state_next = HOLD;
      HOLD: begin
        if (accept)                  state_next = ACCUM;
        else if (bus.sample_out_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy             = (state == ACCUM) || (state == SCALE);
    bus.sample_out_valid = (state == HOLD);
    bus.sample_out       = out_q;
    bus.clip             = clip_q;
    bus.dropped          = dropped_q;
  end

  // NOTE: the voice/mask capture registers carry no reset; every accepted set overwrites them
  // before they are read, so clearing them would only cost reset routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      voice[0] <= bus.sample_in1;
      voice[1] <= bus.sample_in2;
      voice[2] <= bus.sample_in3;
      voice[3] <= bus.sample_in4;
      voice[4] <= bus.sample_in5;
      voice[5] <= bus.sample_in6;
      voice[6] <= bus.sample_in7;
      voice[7] <= bus.sample_in8;
      mask_q   <= bus.mute_mask;
    end
  end

  always_comb begin
    addend = mask_q[idx] ? '0 : {{3{voice[idx][15]}}, voice[idx]};
    scaled = acc >>> OUT_SHIFT;
    if (scaled > SAT_MAX) begin
      clamped = 16'sh7FFF;
      clipped = 1'b1;
    end else if (scaled < SAT_MIN) begin
      clamped = -16'sh8000;
      clipped = 1'b1;
    end else begin
      clamped = scaled[15:0];
      clipped = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= '0;
      acc       <= '0;
      out_q     <= '0;
      clip_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= reject;
      if (accept) begin
        idx <= '0;
        acc <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + addend;
        idx <= idx + 3'd1;
      end
      // sample_out keeps its last value after the ack; only clip follows valid down.
      if (state == SCALE) begin
        out_q  <= clamped;
        clip_q <= clipped;
      end else if ((state == HOLD) && bus.sample_out_ack) begin
        clip_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: expected mixes are queued at each accepted pulse
// and compared (value, clip, latency) when the result first shows up as valid.
module tb_voice_mixer;

  localparam int OUT_SHIFT = 1;

  typedef struct {
    int sample;
    bit clip;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   taken = 1'b0;

  logic signed [15:0] sets [5][8];

  voice_mixer_if bus ();

  voice_mixer #(.OUT_SHIFT(OUT_SHIFT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int set_id, input logic [7:0] mask);
    exp_t e;
    int   sum = 0;
    int   sc;
    for (int i = 0; i < 8; i++)
      if (!mask[i]) sum += int'(sets[set_id][i]);
    sc = sum >>> OUT_SHIFT;
    e.clip = 1'b0;
    if (sc > 32767)       begin sc = 32767;  e.clip = 1'b1; end
    else if (sc < -32768) begin sc = -32768; e.clip = 1'b1; end
    e.sample = sc;
    e.due = 0;
    return e;
  endfunction

  // Drives one pulse across the next rising edge; returns #1 after that edge.
  task automatic send(input int set_id, input logic [7:0] mask, input bit expect_result,
                      input bit with_ack);
    exp_t e;
    @(negedge clk);
    bus.sample_in1 = sets[set_id][0];
    bus.sample_in2 = sets[set_id][1];
    bus.sample_in3 = sets[set_id][2];
    bus.sample_in4 = sets[set_id][3];
    bus.sample_in5 = sets[set_id][4];
    bus.sample_in6 = sets[set_id][5];
    bus.sample_in7 = sets[set_id][6];
    bus.sample_in8 = sets[set_id][7];
    bus.mute_mask = mask;
    bus.samples_in_ready = 1'b1;
    bus.sample_out_ack = with_ack;
    @(posedge clk);
    #1;
    bus.samples_in_ready = 1'b0;
    bus.sample_out_ack = 1'b0;
    if (expect_result) begin
      e = model(set_id, mask);
      e.due = cyc + 9;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.sample_out_valid;
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic ack_and_check(input int exp_sample);
    @(negedge clk);
    bus.sample_out_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_out_ack = 1'b0;
    check("valid_after_ack", int'(bus.sample_out_valid), 0);
    check("clip_after_ack", int'(bus.clip), 0);
    check("out_retained", int'(bus.sample_out), exp_sample);
  endtask

  // Scoreboard monitor: compares each result the first cycle it is valid.
  always @(negedge clk) begin
    exp_t e;
    if (!bus.sample_out_valid) begin
      taken = 1'b0;
    end else if (!taken) begin
      taken = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("mix_value", int'(bus.sample_out), e.sample);
        check("mix_clip", int'(bus.clip), int'(e.clip));
        check("mix_latency", cyc, e.due);
        check("busy_in_hold", int'(bus.busy), 0);
      end
    end
  end

  initial begin
    exp_t e;
    sets[0] = '{16'sd0, 16'sd600, 16'sd1170, 16'sd1190, -16'sd7768, -16'sd15173,
                16'sd1170, 16'sd1170};
    for (int i = 0; i < 8; i++) begin
      sets[1][i] = 16'sh7FFF;
      sets[2][i] = -16'sh8000;
      sets[3][i] = 16'($urandom_range(0, 65535));
      sets[4][i] = 16'($urandom_range(0, 65535));
    end
    bus.samples_in_ready = 1'b0;
    bus.sample_out_ack = 1'b0;
    bus.mute_mask = '0;
    bus.sample_in1 = '0; bus.sample_in2 = '0; bus.sample_in3 = '0; bus.sample_in4 = '0;
    bus.sample_in5 = '0; bus.sample_in6 = '0; bus.sample_in7 = '0; bus.sample_in8 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", int'(bus.sample_out), 0);
    check("rst_valid", int'(bus.sample_out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_clip", int'(bus.clip), 0);
    check("rst_dropped", int'(bus.dropped), 0);
    reset = 1'b1;

    // Nominal mix, then with voices 5 and 6 muted.
    send(0, 8'h00, 1'b1, 1'b0);
    check("busy_after_pulse", int'(bus.busy), 1);
    wait_valid();
    ack_and_check(-8821);
    send(0, 8'b0011_0000, 1'b1, 1'b0);
    wait_valid();
    ack_and_check(2650);

    // Saturation both ways.
    send(1, 8'h00, 1'b1, 1'b0);
    wait_valid();
    ack_and_check(32767);
    send(2, 8'h00, 1'b1, 1'b0);
    wait_valid();
    ack_and_check(-32768);

    // Second pulse at E3 lands in ACCUM and must be dropped.
    send(0, 8'h00, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    send(1, 8'h00, 1'b0, 1'b0);
    check("dropped_pulse", int'(bus.dropped), 1);
    check("busy_during_drop", int'(bus.busy), 1);
    @(posedge clk);
    #1;
    check("dropped_one_cycle", int'(bus.dropped), 0);
    wait_valid();
    ack_and_check(-8821);

    // Held result stays put without ack, then back-to-back ack plus new pulse.
    e = model(3, 8'h05);
    send(3, 8'h05, 1'b1, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_value", int'(bus.sample_out), e.sample);
      check("hold_valid", int'(bus.sample_out_valid), 1);
    end
    send(4, 8'h80, 1'b1, 1'b1);
    check("b2b_valid_fall", int'(bus.sample_out_valid), 0);
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_no_drop", int'(bus.dropped), 0);
    wait_valid();
    e = model(4, 8'h80);
    ack_and_check(e.sample);

    // Reset sampled at E4 aborts the mix; nothing may come out of it.
    send(2, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out", int'(bus.sample_out), 0);
    check("midrst_valid", int'(bus.sample_out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_clip", int'(bus.clip), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    send(0, 8'h00, 1'b1, 1'b0);
    wait_valid();
    ack_and_check(-8821);

    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Sums the eight per-voice samples produced by `dynamics_calc` into one signed 16-bit output sample for the codec path. It sits directly downstream of `dynamics_calc`. It is triggered by that block's `samples_out_ready` pulse and accumulates the voices serially, one per cycle. It then scales and saturates the sum and holds the result behind a valid/ack handshake until the codec side takes it.

## Interface
- `OUT_SHIFT`, default 1: arithmetic right shift applied to the 19-bit sum before saturation (legal range 0..3).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; state clears on a rising edge where `reset`=0.
- `samples_in_ready`  in  1  single-cycle pulse from `dynamics_calc.samples_out_ready`; inputs are valid in this cycle.
- `sample_in1`..`sample_in8`  in  16 each  signed voice samples from `dynamics_calc.sample_out1..8`.
- `mute_mask`  in  8  bit i-1 set excludes voice i; sampled together with the samples.
- `sample_out`  out  16  signed mixed sample.
- `sample_out_valid`  out  1  high while `sample_out` holds an unconsumed result.
- `sample_out_ack`  in  1  consumer takes `sample_out` on any edge where it and `sample_out_valid` are both high.
- `busy`  out  1  high in ACCUM and SCALE.
- `clip`  out  1  high with `sample_out_valid` when the current result was saturated.
- `dropped`  out  1  one-cycle pulse when a `samples_in_ready` pulse is rejected.

## Operation
- States: IDLE, ACCUM, SCALE, HOLD.
- **Transitions**
  - IDLE -> ACCUM on `samples_in_ready`.
  - ACCUM -> SCALE after the 8th voice is added.
  - SCALE -> HOLD unconditionally.
  - HOLD -> IDLE on `sample_out_ack`.
  - HOLD with `sample_out_ack` and `samples_in_ready` both high in the same cycle -> ACCUM, with the new set accepted.
- **Capture:** on acceptance, all eight samples and `mute_mask` are latched into internal registers. The voice index is cleared to 0 and the 19-bit signed accumulator is cleared to 0.
- **ACCUM:** each cycle, add the sign-extended latched sample[idx] unless mute bit idx is set (a muted voice adds 0). Then increment idx. The 8th add occurs when idx=7.
- **Arithmetic:** 19-bit signed accumulator, so no internal overflow for 8 × 16-bit inputs.
  - SCALE computes `acc >>> OUT_SHIFT`, which floors toward negative infinity.
  - The scaled value is clamped to [-32768, 32767].
  - `sample_out` is registered from the clamped value.
  - `clip` is set if clamping changed the value.
- **Rejection:** a `samples_in_ready` pulse in ACCUM or SCALE, or in HOLD without a same-cycle ack, is ignored. `dropped` pulses on the next edge, and the in-flight computation and held output are unaffected.
- **HOLD:** `sample_out` and `clip` stay stable until the ack edge. After the ack, `sample_out` retains its value, while `sample_out_valid` and `clip` go low.
- **Reset:** reset mid-operation (any state) aborts and returns to IDLE; no partial result is emitted.

## Timing
- **Reset values:** `sample_out`=0, `sample_out_valid`=0, `busy`=0, `clip`=0, `dropped`=0. Internal: state=IDLE, idx=0, acc=0.
- **Latency:** with `samples_in_ready` sampled high at edge E0:
  - `busy` goes high after E0.
  - Voices 1..8 are added at E1..E8.
  - SCALE occurs at E9, after which `sample_out_valid`=1 and `busy`=0.
  - Overall, 9 cycles from pulse edge to valid.
- **Throughput:** 10 cycles per sample with an ack in the first HOLD cycle. Back-to-back operation is allowed via a same-cycle ack plus a new pulse.
- **Ack timing:** `sample_out_valid` falls on the same edge that samples `sample_out_ack`=1. An ack while valid is low is ignored.
- **Drop timing:** `dropped` is high for exactly one cycle, after the edge that sampled the rejected pulse.

## Test plan
- **Nominal mix:** inputs 0, 600, 1170, 1190, -7768, -15173, 1170, 1170; mask 0; OUT_SHIFT=1 -> `sample_out`=-8821, `clip`=0. Valid rises exactly 9 edges after the pulse edge.
- **Mute:** same inputs, `mute_mask`=8'b0011_0000 -> `sample_out`=2650, `clip`=0.
- **Saturation:**
  - All inputs 32767 -> `sample_out`=32767, `clip`=1.
  - All inputs -32768 -> `sample_out`=-32768, `clip`=1.
- **Drop:** second pulse 3 cycles after the first (in ACCUM) -> `dropped` pulses once; result equals the first set's mix; only one valid assertion.
- **Handshake and back-to-back:**
  - Hold ack low for 5 cycles -> `sample_out` stable and valid high throughout.
  - Ack together with a new pulse -> valid falls, `busy` rises the next cycle, and the new result appears 9 edges later.
- **Reset mid-ACCUM:** assert `reset`=0 at the E4 edge -> all outputs at reset values, no valid asserted. A subsequent pulse produces the correct mix.
